// File: rtl/rap_timer_pkg.sv
// Shared types and helpers for the capture/PWM timer family.
// State encoding is one-hot so any corrupted value is detectably illegal.
package rap_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RUN  = 2'b10
  } state_t;

  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/interval_capture_10_sync_edge.sv
// Metastability synchroniser for an asynchronous level, plus rising-edge detect.
// Reusable for any async comparator input.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sh;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      prev <= 1'b0;
    end else begin
      sh   <= {sh[STAGES-2:0], d};
      prev <= sh[STAGES-1];
    end
  end

  assign level = sh[STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/interval_capture_10.sv
// Interval timer: counts cycles from start to a qualified stop edge,
// with blanking, optional timeout and a saturating counter.
module interval_capture_10
  import rap_timer_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop_async,
  input  logic [WIDTH-1:0] blank_time,
  input  logic [WIDTH-1:0] timeout,
  output logic [WIDTH-1:0] elapsed,
  output logic [WIDTH-1:0] capture,
  output logic             valid,
  output logic             timed_out,
  output logic             saturated,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] CPRE = CMAX - WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic             stop_lvl;
  logic             stop_rise;
  logic             run;
  logic             hit_stop;
  logic             hit_to;
  logic             at_max;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_stop (
    .clk  (clk),
    .reset(reset),
    .d    (stop_async),
    .level(stop_lvl),
    .rise (stop_rise)
  );

  assign run      = (state == RUN);
  assign at_max   = (count == CMAX);
  assign hit_stop = run & stop_lvl & stop_rise
                  & (count >= blank_time);
  // A qualified stop in the timeout cycle wins.
  assign hit_to   = run & ~hit_stop
                  & (timeout != '0)
                  & (count == timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      capture   <= '0;
      valid     <= 1'b0;
      timed_out <= 1'b0;
      saturated <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      timed_out <= 1'b0;
      if (start) begin
        state     <= RUN;
        busy      <= 1'b1;
        count     <= '0;
        saturated <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (hit_stop) begin
              capture <= count;
              valid   <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else if (hit_to) begin
              capture   <= timeout;
              timed_out <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else if (!at_max) begin
              count <= count + WIDTH'(1);
              if (count == CPRE) saturated <= 1'b1;
            end
          end
          IDLE: begin
            busy <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign elapsed = count;

endmodule

// File: tb/tb_interval_capture_10.sv
// Directed and random checks of interval_capture_10 against a cycle model.
module tb_interval_capture_10;

  localparam int W    = 10;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop_async = 1'b0;
  logic [W-1:0] blank_time = '0;
  logic [W-1:0] timeout = '0;
  logic [W-1:0] elapsed;
  logic [W-1:0] capture;
  logic         valid;
  logic         timed_out;
  logic         saturated;
  logic         busy;

  always #5 clk = ~clk;

  interval_capture_10 #(
    .WIDTH      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop_async(stop_async),
    .blank_time(blank_time),
    .timeout   (timeout),
    .elapsed   (elapsed),
    .capture   (capture),
    .valid     (valid),
    .timed_out (timed_out),
    .saturated (saturated),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model: samples of stop per edge, h[0] newest.
  bit [S:0] h;
  bit       m_run;
  int       m_cnt;
  int       m_cap;
  bit       m_sat;
  bit       m_val;
  bit       m_to;

  function automatic void m_clear();
    h     = '0;
    m_run = 1'b0;
    m_cnt = 0;
    m_cap = 0;
    m_sat = 1'b0;
    m_val = 1'b0;
    m_to  = 1'b0;
  endfunction

  function automatic void m_edge(bit st, bit sp, int bl, int tm);
    bit rise;
    rise  = h[S-1] & ~h[S];
    h     = {h[S-1:0], sp};
    m_val = 1'b0;
    m_to  = 1'b0;
    if (st) begin
      m_run = 1'b1;
      m_cnt = 0;
      m_sat = 1'b0;
    end else if (m_run) begin
      if (rise && m_cnt >= bl) begin
        m_cap = m_cnt;
        m_val = 1'b1;
        m_run = 1'b0;
      end else if (tm != 0 && m_cnt == tm) begin
        m_cap = tm;
        m_to  = 1'b1;
        m_run = 1'b0;
      end else begin
        if (m_cnt < MAXV) m_cnt++;
        if (m_cnt == MAXV) m_sat = 1'b1;
      end
    end
  endfunction

  task automatic cmp();
    chk("elapsed", elapsed, m_cnt);
    chk("capture", capture, m_cap);
    chk("valid", valid, m_val);
    chk("timed_out", timed_out, m_to);
    chk("saturated", saturated, m_sat);
    chk("busy", busy, m_run);
  endtask

  task automatic cyc(input bit st, input bit sp);
    start      = st;
    stop_async = sp;
    @(posedge clk);
    m_edge(st, sp, int'(blank_time), int'(timeout));
    #1 cmp();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stop edge becomes visible in the cycle where count == c.
  task automatic pulse_in(input int c);
    int g = 0;
    while (m_cnt < c - 2 && g < 3000) begin
      cyc(1'b0, 1'b0);
      g++;
    end
    chk("pulse_bound", (g < 3000) ? 1 : 0, 1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_elapsed", elapsed, 0);
    chk("rst_capture", capture, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_saturated", saturated, 0);
    chk("rst_busy", busy, 0);
    m_clear();
    repeat (2) begin
      @(posedge clk);
      m_clear();
      #1 cmp();
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int g;
    m_clear();
    do_reset();

    // basic capture
    blank_time = 10'd0;
    timeout    = 10'd0;
    cyc(1'b1, 1'b0);
    pulse_in(37);
    chk("basic_cap", capture, 37);
    chk("basic_valid", valid, 1);
    chk("basic_busy", busy, 0);
    cyc(1'b0, 1'b0);
    chk("basic_valid_1cyc", valid, 0);

    // blanking
    blank_time = 10'd20;
    cyc(1'b1, 1'b0);
    pulse_in(10);
    chk("blank_ignored", valid, 0);
    chk("blank_busy", busy, 1);
    pulse_in(25);
    chk("blank_cap", capture, 25);
    chk("blank_valid", valid, 1);

    // timeout without stop
    blank_time = 10'd0;
    timeout    = 10'd50;
    cyc(1'b1, 1'b0);
    g = 0;
    while (m_run && g < 200) begin
      cyc(1'b0, 1'b0);
      g++;
    end
    chk("to_bound", (g < 200) ? 1 : 0, 1);
    chk("to_strobe", timed_out, 1);
    chk("to_cap", capture, 50);
    chk("to_valid", valid, 0);

    // stop and timeout in same cycle
    cyc(1'b1, 1'b0);
    pulse_in(50);
    chk("to_stop_valid", valid, 1);
    chk("to_stop_to", timed_out, 0);
    chk("to_stop_cap", capture, 50);

    // saturation
    timeout = 10'd0;
    cyc(1'b1, 1'b0);
    repeat (1030) cyc(1'b0, 1'b0);
    chk("sat_elapsed", elapsed, MAXV);
    chk("sat_flag", saturated, 1);
    chk("sat_busy", busy, 1);
    pulse_in(MAXV);
    chk("sat_cap", capture, MAXV);
    chk("sat_valid", valid, 1);

    // start beats a qualified stop
    cyc(1'b1, 1'b0);
    while (m_cnt < 3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk("prio_valid", valid, 0);
    chk("prio_elapsed", elapsed, 0);
    chk("prio_busy", busy, 1);

    // stop already high at start
    blank_time = 10'd1000;
    repeat (6) cyc(1'b0, 1'b1);
    blank_time = 10'd0;
    cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b1);
    chk("high_valid", valid, 0);
    chk("high_busy", busy, 1);
    cyc(1'b0, 1'b0);
    pulse_in(15);
    chk("high_cap", capture, 15);
    chk("high_valid2", valid, 1);

    // reset mid-run
    cyc(1'b1, 1'b0);
    while (m_cnt < 100) cyc(1'b0, 1'b0);
    chk("mid_elapsed", elapsed, 100);
    do_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("post_rst_valid", valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cap", capture, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit st;
      bit sp;
      if (!m_run && $urandom_range(0, 9) == 0) begin
        blank_time = W'($urandom_range(0, 40));
        timeout    = ($urandom_range(0, 2) == 0) ? '0
                   : W'($urandom_range(5, 90));
      end
      st = ($urandom_range(0, 29) == 0);
      sp = stop_async;
      if ($urandom_range(0, 5) == 0) sp = ~sp;
      if ($urandom_range(0, 699) == 0) do_reset();
      else cyc(st, sp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
